me_unit: RTL and testbench

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and the write-back unit. It registers the execute-stage result bus and takes the synchronous data-SRAM read data that returns one cycle after the execute stage issued the load. For loads it extracts and extends the addressed byte, halfword or word. It presents the packed write-back bus and a forwarding bus under a valid/ready handshake.

---
 rtl/me_unit.sv | 102 ++++++++++
 tb/tb_me_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/me_unit.sv
// Memory-access stage: registers the execute bus, captures synchronous SRAM load data, extracts and extends it.
// Optional macro ME_SUBWORD_EN enables byte/halfword load decoding; without it every load returns the whole word.
module me_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        EX_Valid,
    output logic        ME_Unit_Ready,
    input  logic [73:0] EX_to_ME_Bus,
    input  logic [31:0] data_sram_rdata,
    output logic        ME_Valid,
    input  logic        WB_Unit_Ready,
    output logic [69:0] ME_to_WB_Bus,
    output logic [37:0] ME_Fwd_Bus
);

    logic        r_me_v;
    logic [73:0] r_bus;
    logic [31:0] r_rdata_hold;
    logic        r_hold_vld;

    logic [31:0] w_pc;
    logic        w_res_from_mem;
    logic        w_rf_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_load_data;
    logic [31:0] w_load_val;
    logic [31:0] w_final;

    assign w_pc           = r_bus[73:42];
    assign w_res_from_mem = r_bus[41];
    assign w_rf_we        = r_bus[37];
    assign w_dest         = r_bus[36:32];
    assign w_alu_result   = r_bus[31:0];

    assign ME_Unit_Ready = ~r_me_v | WB_Unit_Ready;
    assign ME_Valid      = r_me_v;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_me_v       <= 1'b0;
            r_bus        <= '0;
            r_rdata_hold <= '0;
            r_hold_vld   <= 1'b0;
        end else begin
            if (ME_Unit_Ready)
                r_me_v <= EX_Valid;
            if (EX_Valid && ME_Unit_Ready) begin
                r_bus      <= EX_to_ME_Bus;
                r_hold_vld <= 1'b0;
            end else if (r_me_v && !WB_Unit_Ready && !r_hold_vld) begin
                // SRAM data is only valid in the first occupied cycle; keep it for the rest of the stall
                r_rdata_hold <= data_sram_rdata;
                r_hold_vld   <= 1'b1;
            end
        end
    end

    assign w_load_data = r_hold_vld ? r_rdata_hold : data_sram_rdata;

`ifdef ME_SUBWORD_EN
    logic [2:0]  w_load_op;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_load_op = r_bus[40:38];
    assign w_half    = w_alu_result[1] ? w_load_data[31:16] : w_load_data[15:0];

    always_comb begin
        w_byte = w_load_data[7:0];
        case (w_alu_result[1:0])
            2'd1:    w_byte = w_load_data[15:8];
            2'd2:    w_byte = w_load_data[23:16];
            2'd3:    w_byte = w_load_data[31:24];
            default: w_byte = w_load_data[7:0];
        endcase
    end

    always_comb begin
        w_load_val = w_load_data;
        case (w_load_op)
            3'b001:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b101:  w_load_val = {24'd0, w_byte};
            3'b010:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b110:  w_load_val = {16'd0, w_half};
            default: w_load_val = w_load_data;
        endcase
    end
`else
    logic w_unused_load_op;

    // load_op travels on the bus but is meaningless in the word-only build
    assign w_unused_load_op = ^r_bus[40:38];
    assign w_load_val       = w_load_data;
`endif

    assign w_final = w_res_from_mem ? w_load_val : w_alu_result;

    assign ME_to_WB_Bus = {w_pc, w_rf_we, w_dest, w_final};
    assign ME_Fwd_Bus   = {r_me_v & w_rf_we, w_dest, w_final};

endmodule

// File: tb/tb_me_unit.sv
// Directed self-checking bench for me_unit; expectations adapt to whether ME_SUBWORD_EN is defined.
module tb_me_unit;

    logic        clk;
    logic        resetn;
    logic        EX_Valid;
    logic        ME_Unit_Ready;
    logic [73:0] EX_to_ME_Bus;
    logic [31:0] data_sram_rdata;
    logic        ME_Valid;
    logic        WB_Unit_Ready;
    logic [69:0] ME_to_WB_Bus;
    logic [37:0] ME_Fwd_Bus;

    int checks = 0;
    int failures = 0;

`ifdef ME_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    me_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .EX_Valid        (EX_Valid),
        .ME_Unit_Ready   (ME_Unit_Ready),
        .EX_to_ME_Bus    (EX_to_ME_Bus),
        .data_sram_rdata (data_sram_rdata),
        .ME_Valid        (ME_Valid),
        .WB_Unit_Ready   (WB_Unit_Ready),
        .ME_to_WB_Bus    (ME_to_WB_Bus),
        .ME_Fwd_Bus      (ME_Fwd_Bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] mkbus(input logic [31:0] pc, input logic rfm, input logic [2:0] lop,
                                          input logic we, input logic [4:0] dest, input logic [31:0] alu);
        return {pc, rfm, lop, we, dest, alu};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] lop, input logic [31:0] addr,
                            input logic [31:0] exp_sub);
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mkbus(32'h1C00_0100, 1'b1, lop, 1'b1, 5'd9, addr);
        step();
        #1;
        chk(tag, {38'd0, ME_to_WB_Bus[31:0]}, {38'd0, (SUB ? exp_sub : 32'h80FF_7F01)});
    endtask

    initial begin
        resetn          = 1'b0;
        EX_Valid        = 1'b0;
        EX_to_ME_Bus    = '0;
        data_sram_rdata = 32'h0;
        WB_Unit_Ready   = 1'b1;
        step();
        step();
        chk("rst_valid", {69'd0, ME_Valid}, 70'd0);
        chk("rst_ready", {69'd0, ME_Unit_Ready}, 70'd1);
        chk("rst_wb_bus", ME_to_WB_Bus, 70'd0);
        chk("rst_fwd_bus", {32'd0, ME_Fwd_Bus}, 70'd0);

        // ALU result passes straight through
        resetn       = 1'b1;
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mkbus(32'h1C00_0000, 1'b0, 3'b000, 1'b1, 5'd5, 32'h1234_5678);
        step();
        EX_Valid = 1'b0;
        #1;
        chk("alu_valid", {69'd0, ME_Valid}, 70'd1);
        chk("alu_wb_bus", ME_to_WB_Bus, {32'h1C00_0000, 1'b1, 5'd5, 32'h1234_5678});
        chk("alu_fwd_bus", {32'd0, ME_Fwd_Bus}, {32'd0, 1'b1, 5'd5, 32'h1234_5678});

        data_sram_rdata = 32'h80FF_7F01;
        load_chk("ld_b_a3",  3'b001, 32'h1000_0003, 32'hFFFF_FF80);
        load_chk("ld_bu_a3", 3'b101, 32'h1000_0003, 32'h0000_0080);
        load_chk("ld_b_a1",  3'b001, 32'h1000_0001, 32'h0000_007F);
        load_chk("ld_h_a2",  3'b010, 32'h1000_0002, 32'hFFFF_80FF);
        load_chk("ld_hu_a0", 3'b110, 32'h1000_0000, 32'h0000_7F01);
        load_chk("ld_hu_a2", 3'b110, 32'h1000_0002, 32'h0000_80FF);
        load_chk("ld_w",     3'b000, 32'h1000_0000, 32'h80FF_7F01);
        load_chk("ld_rsvd",  3'b011, 32'h1000_0003, 32'h80FF_7F01);

        // Bubble empties the stage but the bus register keeps its contents
        EX_Valid = 1'b0;
        step();
        #1;
        chk("bubble_valid", {69'd0, ME_Valid}, 70'd0);
        chk("bubble_fwd_we", {69'd0, ME_Fwd_Bus[37]}, 70'd0);
        chk("bubble_ready", {69'd0, ME_Unit_Ready}, 70'd1);

        // Stall on a load: data must be held once SRAM output moves
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mkbus(32'h1C00_0200, 1'b1, 3'b000, 1'b1, 5'd7, 32'h0000_0100);
        step();
        EX_Valid      = 1'b0;
        WB_Unit_Ready = 1'b0;
        #1;
        chk("stall1_ready", {69'd0, ME_Unit_Ready}, 70'd0);
        chk("stall1_bus", ME_to_WB_Bus, {32'h1C00_0200, 1'b1, 5'd7, 32'h80FF_7F01});
        step();
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("stall2_ready", {69'd0, ME_Unit_Ready}, 70'd0);
        chk("stall2_bus", ME_to_WB_Bus, {32'h1C00_0200, 1'b1, 5'd7, 32'h80FF_7F01});
        step();
        #1;
        chk("stall3_valid", {69'd0, ME_Valid}, 70'd1);
        chk("stall3_bus", ME_to_WB_Bus, {32'h1C00_0200, 1'b1, 5'd7, 32'h80FF_7F01});
        WB_Unit_Ready = 1'b1;
        #1;
        chk("release_ready", {69'd0, ME_Unit_Ready}, 70'd1);
        chk("release_bus", ME_to_WB_Bus, {32'h1C00_0200, 1'b1, 5'd7, 32'h80FF_7F01});
        step();
        #1;
        chk("release_empty", {69'd0, ME_Valid}, 70'd0);

        // Back-to-back: one instruction per cycle with no bubbles
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mkbus(32'h1C00_1000, 1'b0, 3'b000, 1'b1, 5'd1, 32'h0000_0011);
        step();
        EX_to_ME_Bus = mkbus(32'h1C00_1004, 1'b0, 3'b000, 1'b0, 5'd2, 32'h0000_0022);
        #1;
        chk("b2b_0", {68'd0, ME_Valid, ME_Fwd_Bus[37]}, 70'd3);
        chk("b2b_0_bus", ME_to_WB_Bus, {32'h1C00_1000, 1'b1, 5'd1, 32'h0000_0011});
        step();
        EX_to_ME_Bus = mkbus(32'h1C00_1008, 1'b0, 3'b000, 1'b1, 5'd3, 32'h0000_0033);
        #1;
        chk("b2b_1", {68'd0, ME_Valid, ME_Fwd_Bus[37]}, 70'd2);
        chk("b2b_1_bus", ME_to_WB_Bus, {32'h1C00_1004, 1'b0, 5'd2, 32'h0000_0022});
        step();
        EX_Valid = 1'b0;
        #1;
        chk("b2b_2", {69'd0, ME_Valid}, 70'd1);
        chk("b2b_2_bus", ME_to_WB_Bus, {32'h1C00_1008, 1'b1, 5'd3, 32'h0000_0033});
        step();
        #1;
        chk("b2b_end", {69'd0, ME_Valid}, 70'd0);

        // Reset while a stalled load is held
        data_sram_rdata = 32'h80FF_7F01;
        EX_Valid        = 1'b1;
        EX_to_ME_Bus    = mkbus(32'h1C00_2000, 1'b1, 3'b001, 1'b1, 5'd4, 32'h0000_0003);
        step();
        EX_Valid      = 1'b0;
        WB_Unit_Ready = 1'b0;
        step();
        #1;
        chk("pre_rst_valid", {69'd0, ME_Valid}, 70'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        chk("mid_rst_valid", {69'd0, ME_Valid}, 70'd0);
        chk("mid_rst_ready", {69'd0, ME_Unit_Ready}, 70'd1);
        chk("mid_rst_wb_bus", ME_to_WB_Bus, 70'd0);
        chk("mid_rst_fwd_bus", {32'd0, ME_Fwd_Bus}, 70'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
